apb_cmd_master: RTL and testbench

- Upstream neighbour of the timer APB slave; sits between a simple valid/ready command source (CPU model, test sequencer, DMA shim) and the timer's tim_p* port.
- Buffers commands in a small FIFO and converts each into a single APB4 transfer: SETUP phase, then ACCESS phase.
- Returns read data, slave error and a timeout flag on a valid/ready response channel.
- A watchdog terminates ACCESS phases when PREADY never arrives.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/apb_cmd_master.sv | 165 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB types: FSM state encoding plus default-width command/response
// views for blocks and benches that talk to the command master.
package apb_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a
// fall-through head (dout always shows the oldest entry).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Occupancy after this cycle; a simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers and flags; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset; stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Converts queued valid/ready commands into single APB4 transfers
// (SETUP then ACCESS) and returns read data / error / timeout status.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W     = APB_ADDR_W,
  parameter int DATA_W     = APB_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic                tim_pready,
  input  logic [DATA_W-1:0]   tim_prdata,
  input  logic                tim_pslverr
);
  localparam int STRB_W = DATA_W / 8;
  // Wide enough to hold TIMEOUT itself (counter passes TIMEOUT-1 on abort).
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  cmd_t            cmd_in, head;
  logic            fifo_full, fifo_empty;
  apb_state_e      state, state_nxt;
  logic            load;        // head -> bus registers, pop FIFO, enter SETUP
  logic            done;        // ACCESS ends this cycle (ready or abort)
  logic            abort;       // watchdog fired this cycle
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};

  sync_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (cmd_valid & cmd_ready),
    .din   (cmd_in),
    .pop   (load),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Full flag is a flop, so cmd_ready is registered too.
  assign cmd_ready = ~fifo_full;

  // Bus phase and response-valid are decoded straight from the state flop.
  assign tim_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign tim_penable = (state == ST_ACCESS);
  assign rsp_valid   = (state == ST_RESP);

  // The TIMEOUT-th stalled ACCESS cycle is the last one tolerated.
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

  // State register; reset drops any in-flight transfer without a response.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and the per-cycle load/complete strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_SETUP;
          load      = 1'b1;
        end
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        // pready wins over the watchdog on the final allowed cycle.
        if (tim_pready) begin
          state_nxt = ST_RESP;
          done      = 1'b1;
        end else if (wd_expired) begin
          state_nxt = ST_RESP;
          done      = 1'b1;
          abort     = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            state_nxt = ST_SETUP;
            load      = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Watchdog: cleared in SETUP, counts stalled ACCESS cycles.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state == ST_SETUP)
      wd_cnt <= '0;
    else if (state == ST_ACCESS && !tim_pready)
      wd_cnt <= wd_cnt + 1'b1;
  end

  // Bus address/control/data registers: loaded on entry to SETUP and held
  // through ACCESS; strobes are zero for reads and outside a transfer.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tim_pwrite <= 1'b0;
      tim_paddr  <= '0;
      tim_pwdata <= '0;
      tim_pstrb  <= '0;
    end else if (load) begin
      tim_pwrite <= head.write;
      tim_paddr  <= head.addr;
      tim_pwdata <= head.wdata;
      tim_pstrb  <= head.write ? head.strb : '0;
    end else if (done) begin
      tim_pstrb  <= '0;
    end
  end

  // Response capture at the end of ACCESS; held until the next transfer ends.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (done) begin
      rsp_timeout <= abort;
      rsp_err     <= abort | tim_pslverr;
      rsp_rdata   <= (abort || tim_pwrite) ? '0 : tim_prdata;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed vector table, multi-cycle corner
// sequences, and a randomized run against a queue-based reference model.
module tb_apb_cmd_master;
  import apb_pkg::*;

  logic        sys_clk, sys_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        tim_psel, tim_penable, tim_pwrite, tim_pready, tim_pslverr;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata, tim_prdata;
  logic [3:0]  tim_pstrb;

  apb_cmd_master #(.ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_pready(tim_pready), .tim_prdata(tim_prdata), .tim_pslverr(tim_pslverr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h1234_5678;
    if (i == 3) return 32'hCAFE_F00D;
    return 32'(i) * 32'h0101_0101;
  endfunction

  // ---------------- slave environment ----------------
  // Wait states come from addr[3:2] unless overridden; addr[11:10]=11 never
  // answers, =01 answers with PSLVERR. Word index is addr[5:2].
  int          ovr_wait;
  bit          ovr_hang, ovr_err;
  int          wcnt;
  int          slv_w;
  logic        slv_hang;
  logic [31:0] slv_mem [16];

  assign slv_w       = (ovr_wait >= 0) ? ovr_wait : int'(tim_paddr[3:2]);
  assign slv_hang    = ovr_hang || (tim_paddr[11:10] == 2'b11);
  assign tim_pready  = tim_psel && tim_penable && !slv_hang && (wcnt == slv_w);
  assign tim_pslverr = tim_pready && (ovr_err || (tim_paddr[11:10] == 2'b01));
  assign tim_prdata  = tim_pready ? slv_mem[tim_paddr[5:2]] : 32'h0;

  always @(posedge sys_clk) begin
    wcnt <= (tim_psel && tim_penable && !tim_pready) ? wcnt + 1 : 0;
    if (sys_rst) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= init_word(i);
    end else if (tim_pready && tim_pwrite && !tim_pslverr) begin
      for (int b = 0; b < 4; b++)
        if (tim_pstrb[b]) slv_mem[tim_paddr[5:2]][8*b +: 8] <= tim_pwdata[8*b +: 8];
    end
  end

  // Protocol monitor: bus fields stable SETUP->ACCESS, no read strobes,
  // timeout never without err.
  int          mon_bad = 0;
  logic [48:0] su_bus;
  always @(negedge sys_clk) begin
    if (tim_psel && !tim_penable) su_bus <= {tim_paddr, tim_pwrite, tim_pstrb, tim_pwdata};
    if ((tim_psel && tim_penable && ({tim_paddr, tim_pwrite, tim_pstrb, tim_pwdata} != su_bus)) ||
        (tim_psel && !tim_pwrite && tim_pstrb != 4'h0) ||
        (rsp_valid && rsp_timeout && !rsp_err))
      mon_bad <= mon_bad + 1;
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    apb_cmd_t cmd;
    int       wt;
    bit       hang;
    bit       err;
    apb_rsp_t exp;
    int       lat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input bit w, input logic [11:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int wt, input bit hang, input bit err,
                              input logic [31:0] erd, input bit eerr, input bit eto, input int lat);
    vec_t v;
    v.cmd.write = w; v.cmd.addr = a; v.cmd.wdata = d; v.cmd.strb = s;
    v.wt = wt; v.hang = hang; v.err = err;
    v.exp.rdata = erd; v.exp.err = eerr; v.exp.timeout = eto;
    v.lat = lat;
    return v;
  endfunction

  // One command from idle; checks phase timing, latency, ACCESS length,
  // strobes, response fields, response hold and release.
  task automatic run_vec(input vec_t v, input int idx);
    int lat, acc, sbad;
    apb_rsp_t r0;
    ovr_wait = v.wt; ovr_hang = v.hang; ovr_err = v.err;
    rsp_ready = 1'b0;
    cmd_write = v.cmd.write; cmd_addr = v.cmd.addr;
    cmd_wdata = v.cmd.wdata; cmd_strb = v.cmd.strb;
    cmd_valid = 1'b1;
    check($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
    lat = 0; acc = 0; sbad = 0;
    while (!rsp_valid && lat < 40) begin
      tick;
      lat++;
      if (lat == 1) check($sformatf("v%0d_setup", idx), {tim_psel, tim_penable}, 2'b10);
      if (lat == 2) check($sformatf("v%0d_access", idx), {tim_psel, tim_penable}, 2'b11);
      if (tim_psel && tim_penable) begin
        acc++;
        if (tim_pstrb != (v.cmd.write ? v.cmd.strb : 4'h0)) sbad++;
      end
    end
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_access_cycles", idx), acc, v.lat - 2);
    check($sformatf("v%0d_pstrb", idx), sbad, 0);
    r0 = '{rdata: rsp_rdata, err: rsp_err, timeout: rsp_timeout};
    check($sformatf("v%0d_rsp", idx), r0, v.exp);
    tick;
    check($sformatf("v%0d_rsp_hold", idx), {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, r0});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check($sformatf("v%0d_release", idx), {rsp_valid, tim_psel}, 2'b00);
    ovr_hang = 1'b0; ovr_err = 1'b0; ovr_wait = -1;
  endtask

  // Reference model: executes commands in acceptance order on its own copy
  // of the slave's register file.
  logic [31:0] ref_mem [16];
  apb_rsp_t    exp_q[$];

  task automatic ref_exec(input apb_cmd_t c);
    apb_rsp_t r;
    int idx;
    idx = int'(c.addr[5:2]);
    r = '0;
    if (c.addr[11:10] == 2'b11) begin
      r.err = 1'b1; r.timeout = 1'b1;
    end else begin
      r.err = (c.addr[11:10] == 2'b01);
      if (!c.write) r.rdata = ref_mem[idx];
      else if (!r.err)
        for (int b = 0; b < 4; b++)
          if (c.strb[b]) ref_mem[idx][8*b +: 8] = c.wdata[8*b +: 8];
    end
    exp_q.push_back(r);
  endtask

  // ---------------- test ----------------
  initial begin
    int cnt, cyc, sent, rcvd, seen;
    int rcyc[5];
    logic [31:0] rdat[5];
    bit push_now, pop_now;
    apb_rsp_t got, exp;
    apb_cmd_t c;

    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
    ovr_wait = -1; ovr_hang = 1'b0; ovr_err = 1'b0;
    tick; tick;
    check("rst_ready_valid", {cmd_ready, rsp_valid}, 2'b10);
    check("rst_bus_ctl", {tim_psel, tim_penable, tim_pwrite, tim_pstrb}, 0);
    check("rst_bus_data", {tim_paddr, tim_pwdata}, 0);
    check("rst_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 0);
    sys_rst = 1'b0;
    tick;

    // write rd err?  addr      wdata        strb wait hang err  exp_rdata   e_err to lat
    vq.push_back(mk(1, 12'h000, 32'h0000_0001, 4'hF, 0,  0, 0, 32'h0,        0, 0, 3));
    vq.push_back(mk(0, 12'h004, 32'h0,         4'hF, 3,  0, 0, 32'h1234_5678, 0, 0, 6));
    vq.push_back(mk(1, 12'h008, 32'hAABB_CCDD, 4'h5, 1,  0, 0, 32'h0,        0, 0, 4));
    vq.push_back(mk(0, 12'h008, 32'h0,         4'h0, 0,  0, 0, 32'h02BB_02DD, 0, 0, 3));
    vq.push_back(mk(1, 12'h00C, 32'h5555_5555, 4'hF, 0,  0, 1, 32'h0,        1, 0, 3));
    vq.push_back(mk(0, 12'h00C, 32'h0,         4'h0, 2,  0, 1, 32'hCAFE_F00D, 1, 0, 5));
    vq.push_back(mk(0, 12'h010, 32'h0,         4'h0, 0,  1, 0, 32'h0,        1, 1, 18));
    vq.push_back(mk(0, 12'h010, 32'h0,         4'h0, 15, 0, 0, 32'h0404_0404, 0, 0, 18));
    vq.push_back(mk(1, 12'h014, 32'hDEAD_BEEF, 4'h3, 0,  1, 0, 32'h0,        1, 1, 18));
    foreach (vq[i]) run_vec(vq[i], i);
    check("timer_enable_set", slv_mem[0][0], 1'b1);

    // Backpressure: five reads pushed back-to-back while the first response
    // is held; FIFO fills to FIFO_DEPTH with one transfer outstanding.
    ovr_wait = 0; rsp_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h014 + 12'(4 * i);
      if (cmd_ready) cnt++;
      tick;
    end
    cmd_valid = 1'b0;
    check("bp_accepted", cnt, 5);
    check("bp_full", cmd_ready, 1'b0);
    seen = 0;
    repeat (6) begin
      tick;
      if (tim_psel || !rsp_valid || cmd_ready) seen++;
    end
    check("bp_no_second_setup", seen, 0);
    rsp_ready = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 5 && cyc < 40) begin
      if (rsp_valid) begin rdat[cnt] = rsp_rdata; rcyc[cnt] = cyc; cnt++; end
      tick;
      cyc++;
    end
    rsp_ready = 1'b0;
    check("bp_completed", cnt, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_order%0d", i), rdat[i], init_word(5 + i));
      if (i > 0) check($sformatf("bp_gap%0d", i), rcyc[i] - rcyc[i-1], 3);
    end
    check("bp_drained", {cmd_ready, rsp_valid, tim_psel}, 3'b100);
    ovr_wait = -1;

    // Reset during the 2nd ACCESS cycle with two commands queued.
    ovr_hang = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020 + 12'(4 * i);
      cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF;
      tick;
    end
    cmd_valid = 1'b0;
    tick;
    check("rst_mid_in_access", {tim_psel, tim_penable}, 2'b11);
    sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0; ovr_hang = 1'b0;
    check("rst_mid_after", {tim_psel, tim_penable, rsp_valid, cmd_ready}, 4'b0001);
    seen = 0;
    repeat (12) begin
      tick;
      if (tim_psel || rsp_valid) seen++;
    end
    check("rst_flushed", seen, 0);

    // Randomized traffic with random response backpressure.
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 60 && cyc < 20000) begin
      if (!cmd_valid && sent < 60 && ($urandom % 3) != 0) begin
        cnt = int'($urandom % 8);
        cmd_addr  = 12'($urandom);
        cmd_addr[11:10] = (cnt == 0) ? 2'b11 : (cnt < 3) ? 2'b01 : 2'b00;
        cmd_write = 1'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_valid = 1'b1;
      end
      rsp_ready = ($urandom % 4) != 0;
      push_now = cmd_valid && cmd_ready;
      pop_now  = rsp_valid && rsp_ready;
      got = '{rdata: rsp_rdata, err: rsp_err, timeout: rsp_timeout};
      c = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};
      tick;
      cyc++;
      if (push_now) begin
        ref_exec(c);
        sent++;
        cmd_valid = 1'b0;
      end
      if (pop_now) begin
        if (exp_q.size() == 0) check("rnd_unexpected_rsp", 1, 0);
        else begin
          exp = exp_q.pop_front();
          check($sformatf("rnd_rsp%0d", rcvd), got, exp);
        end
        rcvd++;
      end
    end
    rsp_ready = 1'b0;
    check("rnd_all_responses", rcvd, 60);
    check("protocol_monitor", mon_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
